// File: rtl/bmult_pipe.sv
// bmult_pipe: pipelined WA x WB multiplier with per-operand signed/unsigned mode and an exact WA+WB-bit product.
// Latency: LAT register stages (Baugh-Wooley bit heap -> carry-save compression -> carry-propagate add).
// Backpressure: valid/ready with per-stage bubble collapsing; holds up to LAT operations while out_ready is low.
//
// Ports:
//   clk, rst_n             clock, async active-low reset
//   in_valid/in_ready      input handshake for a, b, a_signed, b_signed
//   a [WA], b [WB]         operands; a_signed/b_signed select two's complement per operand
//   out_valid/out_ready    output handshake for p
//   p [WA+WB]              exact product (two's complement, unsigned-exact when both operands unsigned)
module bmult_pipe #(
  parameter int WA  = 8,
  parameter int WB  = 8,
  parameter int LAT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WA-1:0]    a,
  input  logic [WB-1:0]    b,
  input  logic             a_signed,
  input  logic             b_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WA+WB-1:0] p
);

  if (WA < 2 || WA > 32 || WB < 2 || WB > 32 || LAT < 1 || LAT > 8) begin : g_bad_param
    $error("bmult_pipe: WA/WB must be 2..32 and LAT 1..8");
  end

  localparam int W  = WA + WB;
  // Each operand is extended by one bit (sign or zero per its mode bit), which turns every
  // mode combination into one signed (WA+1)x(WB+1) product. The mode bits are thereby folded
  // into the heap itself, so no later stage needs to carry them.
  localparam int NA = WA + 1;
  localparam int NB = WB + 1;
  localparam int NR = NB + 1;   // NB partial-product rows plus one constant row

  typedef logic [NR-1:0][W-1:0] rows_t;

  // Baugh-Wooley heap, truncated to W columns. The product fits in W bits for every mode,
  // so the dropped top columns (including the 2^(W+1) correction term) never matter.
  function automatic rows_t build_heap(input logic [WA-1:0] xa, input logic [WB-1:0] xb,
                                       input logic sa, input logic sb);
    logic [NA-1:0] ax;
    logic [NB-1:0] bx;
    rows_t         r;
    logic          bit_v;
    ax = {sa & xa[WA-1], xa};
    bx = {sb & xb[WB-1], xb};
    r  = '0;
    for (int i = 0; i < NB; i++) begin
      for (int j = 0; j < NA; j++) begin
        if (i + j < W) begin
          bit_v = ax[j] & bx[i];
          // Terms pairing exactly one sign bit carry negative weight: complement them.
          if ((j == NA-1) != (i == NB-1)) bit_v = ~bit_v;
          r[i][i+j] = bit_v;
        end
      end
    end
    r[NR-1] = (W'(1) << WA) + (W'(1) << WB);
    return r;
  endfunction

  // One level of 3:2 compression over the row array; surviving rows stay packed at the bottom.
  function automatic rows_t csa_level(input rows_t r);
    rows_t o;
    int    k;
    o = '0;
    k = 0;
    for (int g = 0; g < NR/3; g++) begin
      o[k]   = r[3*g] ^ r[3*g+1] ^ r[3*g+2];
      o[k+1] = ((r[3*g] & r[3*g+1]) | (r[3*g] & r[3*g+2]) | (r[3*g+1] & r[3*g+2])) << 1;
      k      = k + 2;
    end
    for (int i = 3*(NR/3); i < NR; i++) begin
      o[k] = r[i];
      k    = k + 1;
    end
    return o;
  endfunction

  function automatic logic [W-1:0] cpa(input rows_t r);
    logic [W-1:0] s;
    s = '0;
    for (int i = 0; i < NR; i++) s = s + r[i];
    return s;
  endfunction

  // Levels needed to bring NR rows down to two.
  function automatic int num_levels(input int n);
    int m, c;
    m = n;
    c = 0;
    for (int i = 0; i < 32; i++) begin
      if (m > 2) begin
        m = 2*(m/3) + m%3;
        c = c + 1;
      end
    end
    return c;
  endfunction

  // ---------------------------------------------------------------- stage control
  logic [LAT:1]   v_q, v_d;
  logic [LAT+1:1] ld;      // ld[k]: stage k loads this cycle; ld[LAT+1] is the downstream take
  logic [LAT:1]   v_src;   // valid bit arriving at each stage
  logic [LAT:1]   en;      // stage k captures real data
  logic [W-1:0]   p_q, p_d;

  always_comb begin
    ld          = '0;
    ld[LAT+1]   = out_ready;
    for (int k = LAT; k >= 1; k--) ld[k] = !v_q[k] || ld[k+1];
    v_src = LAT'({v_q, in_valid});
    // Data registers only move when real data arrives, so p stays at its last value (0 after
    // reset) instead of picking up an empty stage's contents.
    en    = ld[LAT:1] & v_src;
    v_d   = (ld[LAT:1] & v_src) | (~ld[LAT:1] & v_q);
  end

  // ---------------------------------------------------------------- datapath
  if (LAT == 1) begin : g_single
    always_comb begin
      p_d = p_q;
      if (en[1]) p_d = cpa(build_heap(a, b, a_signed, b_signed));
    end
  end else begin : g_pipe
    localparam int NLEV = num_levels(NR);
    localparam int NMID = (LAT > 2) ? (LAT - 2) : 1;
    localparam int LPS  = (NLEV + NMID - 1) / NMID;   // compression levels per middle stage

    rows_t rows_q [1:LAT-1];
    rows_t rows_d [1:LAT-1];

    always_comb begin
      rows_d = rows_q;
      if (en[1]) rows_d[1] = build_heap(a, b, a_signed, b_signed);
      for (int k = 2; k < LAT; k++) begin
        if (en[k]) begin
          rows_d[k] = rows_q[k-1];
          for (int l = 0; l < LPS; l++) rows_d[k] = csa_level(rows_d[k]);
        end
      end
      p_d = p_q;
      if (en[LAT]) p_d = cpa(rows_q[LAT-1]);
    end

    always_ff @(posedge clk) begin
      rows_q <= rows_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      p_q <= '0;
    end else begin
      v_q <= v_d;
      p_q <= p_d;
    end
  end

  assign in_ready  = ld[1];
  assign out_valid = v_q[LAT];
  assign p         = p_q;

endmodule

// File: tb/tb_bmult_pipe.sv
module tb_bmult_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Main instance: WA=WB=8, LAT=3
  logic        m_iv = 1'b0, m_ir, m_as = 1'b0, m_bs = 1'b0, m_ov, m_ordy = 1'b0;
  logic [7:0]  m_a = '0, m_b = '0;
  logic [15:0] m_p;

  bmult_pipe #(.WA(8), .WB(8), .LAT(3)) u_main (
    .clk(clk), .rst_n(rst_n), .in_valid(m_iv), .in_ready(m_ir), .a(m_a), .b(m_b),
    .a_signed(m_as), .b_signed(m_bs), .out_valid(m_ov), .out_ready(m_ordy), .p(m_p));

  // Sweep instances
  logic [2:0]  s_iv = '0, s_ir, s_as = '0, s_bs = '0, s_ov, s_ordy = '0;
  logic [11:0] a0 = '0;  logic [4:0]  b0 = '0;  logic [16:0] p0;
  logic [15:0] a1 = '0;  logic [15:0] b1 = '0;  logic [31:0] p1;
  logic [1:0]  a2 = '0;  logic [1:0]  b2 = '0;  logic [3:0]  p2;

  bmult_pipe #(.WA(12), .WB(5), .LAT(1)) u_s0 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_iv[0]), .in_ready(s_ir[0]), .a(a0), .b(b0),
    .a_signed(s_as[0]), .b_signed(s_bs[0]), .out_valid(s_ov[0]), .out_ready(s_ordy[0]), .p(p0));
  bmult_pipe #(.WA(16), .WB(16), .LAT(5)) u_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_iv[1]), .in_ready(s_ir[1]), .a(a1), .b(b1),
    .a_signed(s_as[1]), .b_signed(s_bs[1]), .out_valid(s_ov[1]), .out_ready(s_ordy[1]), .p(p1));
  bmult_pipe #(.WA(2), .WB(2), .LAT(8)) u_s2 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_iv[2]), .in_ready(s_ir[2]), .a(a2), .b(b2),
    .a_signed(s_as[2]), .b_signed(s_bs[2]), .out_valid(s_ov[2]), .out_ready(s_ordy[2]), .p(p2));

  // Reference: interpret operands per mode, multiply as integers, keep wa+wb bits.
  function automatic longint ref_mul(input longint ua, input longint ub, input bit sa, input bit sb,
                                     input int wa, input int wb);
    longint va, vb, m;
    va = ua & ((longint'(1) << wa) - 1);
    vb = ub & ((longint'(1) << wb) - 1);
    if (sa && va[wa-1]) va = va - (longint'(1) << wa);
    if (sb && vb[wb-1]) vb = vb - (longint'(1) << wb);
    m = (longint'(1) << (wa + wb)) - 1;
    return (va * vb) & m;
  endfunction

  // Issue one operation on the idle main instance with out_ready=1; report the product and
  // the number of edges from the start of the acceptance cycle until out_valid is seen.
  task automatic do_op(input logic [7:0] xa, input logic [7:0] xb, input logic xas, input logic xbs,
                       output logic [15:0] rp, output int rlat);
    int t0;
    @(negedge clk);
    m_a = xa; m_b = xb; m_as = xas; m_bs = xbs; m_iv = 1'b1; m_ordy = 1'b1;
    t0 = cyc; rlat = -1; rp = '0;
    for (int i = 0; i < 20 && rlat < 0; i++) begin
      @(negedge clk);
      m_iv = 1'b0;
      if (m_ov) begin
        rlat = cyc - t0;
        rp   = m_p;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    #1;
    n_cmp++; if (m_ov !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", m_ov); end
    n_cmp++; if (m_p !== 16'h0) begin n_err++; $display("FAIL reset_p: got %h want 0000", m_p); end
    n_cmp++; if (m_ir !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", m_ir); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (m_ir !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready: got %b want 1", m_ir); end
    @(negedge clk);
    n_cmp++; if (m_ov !== 1'b0) begin n_err++; $display("FAIL post_reset_out_valid: got %b want 0", m_ov); end
  endtask

  task automatic test_unsigned_corner;
    logic [15:0] rp; int rl;
    do_op(8'hFF, 8'hFF, 1'b0, 1'b0, rp, rl);
    n_cmp++; if (rp !== 16'hFE01) begin n_err++; $display("FAIL uns_ff_ff: got %h want fe01", rp); end
    n_cmp++; if (rl !== 3) begin n_err++; $display("FAIL uns_latency: got %0d want 3", rl); end
  endtask

  task automatic test_signed_corners;
    logic [15:0] rp; int rl;
    do_op(8'h80, 8'h80, 1'b1, 1'b1, rp, rl);
    n_cmp++; if (rp !== 16'h4000) begin n_err++; $display("FAIL sgn_80_80: got %h want 4000", rp); end
    n_cmp++; if (rl !== 3) begin n_err++; $display("FAIL sgn_latency: got %0d want 3", rl); end
    do_op(8'h80, 8'h7F, 1'b1, 1'b1, rp, rl);
    n_cmp++; if (rp !== 16'hC080) begin n_err++; $display("FAIL sgn_80_7f: got %h want c080", rp); end
  endtask

  task automatic test_mixed_mode;
    logic [15:0] rp; int rl;
    do_op(8'hFF, 8'hFF, 1'b1, 1'b0, rp, rl);
    n_cmp++; if (rp !== 16'hFF01) begin n_err++; $display("FAIL mixed_sa: got %h want ff01", rp); end
    do_op(8'hFF, 8'hFF, 1'b0, 1'b1, rp, rl);
    n_cmp++; if (rp !== 16'hFF01) begin n_err++; $display("FAIL mixed_sb: got %h want ff01", rp); end
  endtask

  task automatic test_back_to_back;
    longint q[$];
    longint e;
    int acc = 0, del = 0, irdy_low = 0;
    for (int t = 0; t < 24 + 3; t++) begin
      @(negedge clk);
      m_ordy = 1'b1;
      if (t < 24) begin
        m_a = 8'($urandom); m_b = 8'($urandom);
        m_as = 1'($urandom); m_bs = 1'($urandom); m_iv = 1'b1;
      end else m_iv = 1'b0;
      #1;
      if (!m_ir) irdy_low++;
      if (m_iv && m_ir) begin q.push_back(ref_mul(longint'(m_a), longint'(m_b), m_as, m_bs, 8, 8)); acc++; end
      if (m_ov && m_ordy) begin
        e = (q.size() > 0) ? q.pop_front() : -1;
        n_cmp++; if (longint'(m_p) !== e) begin n_err++; $display("FAIL b2b_value: got %h want %h", m_p, e); end
        del++;
      end
    end
    m_iv = 1'b0;
    n_cmp++; if (irdy_low !== 0) begin n_err++; $display("FAIL b2b_in_ready_low_cycles: got %0d want 0", irdy_low); end
    n_cmp++; if (del !== 24) begin n_err++; $display("FAIL b2b_throughput: got %0d results want 24", del); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_backpressure;
    longint q[$];
    longint e;
    int sent = 0, acc = 0, del = 0;
    bit dropped = 0, held = 0;
    logic [15:0] held_p = '0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      m_ordy = !(t >= 2 && t <= 7);
      if (sent < 6) begin
        m_a = 8'(sent * 3); m_b = 8'(sent + 1); m_as = 1'b0; m_bs = 1'b0; m_iv = 1'b1;
      end else m_iv = 1'b0;
      #1;
      if (held) begin
        n_cmp++;
        if (m_ov !== 1'b1 || m_p !== held_p) begin
          n_err++; $display("FAIL bp_hold: got vld=%b p=%h want vld=1 p=%h", m_ov, m_p, held_p);
        end
      end
      held = m_ov && !m_ordy;
      held_p = m_p;
      if (!m_ir && !dropped) begin
        dropped = 1;
        n_cmp++; if (acc - del !== 3) begin n_err++; $display("FAIL bp_held_count: got %0d want 3", acc - del); end
      end
      if (m_iv && m_ir) begin q.push_back(ref_mul(longint'(m_a), longint'(m_b), 0, 0, 8, 8)); acc++; sent++; end
      if (m_ov && m_ordy) begin
        e = (q.size() > 0) ? q.pop_front() : -1;
        n_cmp++; if (longint'(m_p) !== e) begin n_err++; $display("FAIL bp_value: got %h want %h", m_p, e); end
        del++;
      end
    end
    m_iv = 1'b0;
    n_cmp++; if (!dropped) begin n_err++; $display("FAIL bp_in_ready_drop: got never want drop"); end
    n_cmp++; if (del !== 6) begin n_err++; $display("FAIL bp_delivered: got %0d want 6", del); end
  endtask

  task automatic test_reset_midflight;
    logic [15:0] rp; int rl, spur = 0;
    longint e;
    @(negedge clk);
    m_ordy = 1'b0; m_as = 1'b0; m_bs = 1'b0;
    m_a = 8'd7; m_b = 8'd9; m_iv = 1'b1;
    @(negedge clk);
    m_a = 8'd11; m_b = 8'd13;
    @(negedge clk);
    m_iv = 1'b0;
    @(negedge clk);
    n_cmp++; if (m_ov !== 1'b1) begin n_err++; $display("FAIL rst_pre_valid: got %b want 1", m_ov); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (m_ov !== 1'b0) begin n_err++; $display("FAIL rst_async_valid: got %b want 0", m_ov); end
    n_cmp++; if (m_p !== 16'h0) begin n_err++; $display("FAIL rst_async_p: got %h want 0000", m_p); end
    @(negedge clk);
    rst_n = 1'b1;
    m_ordy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (m_ov) spur++;
    end
    n_cmp++; if (spur !== 0) begin n_err++; $display("FAIL rst_stale_outputs: got %0d want 0", spur); end
    e = ref_mul(longint'(8'hC3), longint'(8'h5A), 1, 0, 8, 8);
    do_op(8'hC3, 8'h5A, 1'b1, 1'b0, rp, rl);
    n_cmp++; if (longint'(rp) !== e) begin n_err++; $display("FAIL rst_new_value: got %h want %h", rp, e); end
    n_cmp++; if (rl !== 3) begin n_err++; $display("FAIL rst_new_latency: got %0d want 3", rl); end
  endtask

  task automatic test_sweep(input int c);
    longint q[$];
    int     acc_q[$];
    int     wa, wb, lat;
    int     acc = 0, del = 0, guard = 0, last_stall = -1, ae;
    bit     iv, ordy, ras, rbs, irdy, ovld;
    logic [31:0] ra, rb;
    longint pv, e;
    localparam int NOPS = 10000;
    case (c)
      0: begin wa = 12; wb = 5;  lat = 1; end
      1: begin wa = 16; wb = 16; lat = 5; end
      default: begin wa = 2; wb = 2; lat = 8; end
    endcase
    while (del < NOPS && guard < 40000) begin
      @(negedge clk);
      guard++;
      iv   = (acc < NOPS) && ($urandom_range(0, 4) != 0);
      ordy = (acc >= NOPS) || ($urandom_range(0, 4) != 0);
      ra = $urandom; rb = $urandom;
      ras = 1'($urandom); rbs = 1'($urandom);
      case (c)
        0: begin a0 = ra[11:0]; b0 = rb[4:0]; end
        1: begin a1 = ra[15:0]; b1 = rb[15:0]; end
        default: begin a2 = ra[1:0]; b2 = rb[1:0]; end
      endcase
      s_iv[c] = iv; s_ordy[c] = ordy; s_as[c] = ras; s_bs[c] = rbs;
      #1;
      irdy = s_ir[c]; ovld = s_ov[c];
      case (c)
        0: pv = longint'(p0);
        1: pv = longint'(p1);
        default: pv = longint'(p2);
      endcase
      if (iv && irdy) begin
        q.push_back(ref_mul(longint'(ra), longint'(rb), ras, rbs, wa, wb));
        acc_q.push_back(cyc + 1);
        acc++;
      end
      if (ovld && ordy) begin
        if (q.size() == 0) begin
          n_cmp++; n_err++; $display("FAIL sweep%0d_spurious: got output want none", c);
        end else begin
          e = q.pop_front();
          ae = acc_q.pop_front();
          n_cmp++; if (pv !== e) begin n_err++; $display("FAIL sweep%0d_value: got %h want %h", c, pv, e); end
          if (last_stall <= ae) begin
            n_cmp++;
            if (cyc + 1 !== ae + lat) begin
              n_err++; $display("FAIL sweep%0d_latency: got %0d want %0d", c, cyc + 1 - ae, lat);
            end
          end
        end
        del++;
      end
      if (!ordy) last_stall = cyc + 1;
    end
    s_iv[c] = 1'b0;
    n_cmp++; if (del !== NOPS) begin n_err++; $display("FAIL sweep%0d_complete: got %0d want %0d", c, del, NOPS); end
  endtask

  initial begin
    test_reset;
    test_unsigned_corner;
    test_signed_corners;
    test_mixed_mode;
    test_back_to_back;
    test_backpressure;
    test_reset_midflight;
    fork
      test_sweep(0);
      test_sweep(1);
      test_sweep(2);
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
